// File: rtl/o_bus_pack_fifo.sv
// Packs picked words from the output bus mux into wide lines and buffers the lines in a show-ahead FIFO.
// Latency: a completed line is visible on o_valid/o_data the cycle after its last word when the FIFO is empty.
// Backpressure: downstream pops with i_ready; a line completing while full with no pop is dropped (o_overflow, sticky).
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   i_valid, i_data, i_en picked word in; words accepted only when i_valid && i_en
//   o_valid, o_data       show-ahead head line (word 0 at LSBs), zero when empty
//   i_ready               downstream accepts head line when o_valid && i_ready
//   o_count, o_full       lines stored, FIFO full
//   o_overflow            sticky: a completed line was dropped
//   i_flush               only with `define O_BUS_PACK_FLUSH_EN: push the partial line, upper slots zero
//
// Optional feature macro: O_BUS_PACK_FLUSH_EN (adds i_flush).

// Generic show-ahead FIFO used for the line buffer.
// Latency: a pushed entry is readable the cycle after the push.
// Backpressure: caller must only push when not full or when popping in the same cycle.
module o_bus_pack_line_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_vld,
   input  logic [W-1:0]               wr_dat,
   output logic                       rd_vld,
   input  logic                       rd_rdy,
   output logic [W-1:0]               rd_dat,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = rd_vld && rd_rdy;
   assign rd_vld = (count != '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_vld, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // When full with push+pop together wr_ptr == rd_ptr: the head is read
   // before the edge and overwritten by the new line at the edge.
   always_ff @(posedge clk) begin
      if (wr_vld) mem[wr_ptr] <= wr_dat;
   end
endmodule

module o_bus_pack_fifo #(
   parameter int DATA_WIDTH  = 16,
   parameter int PACK_FACTOR = 4,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                                clk,
   input  logic                                rst,
`ifdef O_BUS_PACK_FLUSH_EN
   input  logic                                i_flush,
`endif
   input  logic                                i_valid,
   input  logic [DATA_WIDTH-1:0]               i_data,
   input  logic                                i_en,
   output logic                                o_valid,
   output logic [PACK_FACTOR*DATA_WIDTH-1:0]   o_data,
   input  logic                                i_ready,
   output logic [$clog2(FIFO_DEPTH):0]         o_count,
   output logic                                o_full,
   output logic                                o_overflow
);
   localparam int LW = PACK_FACTOR * DATA_WIDTH;
   localparam int CW = $clog2(PACK_FACTOR);
   localparam logic [CW-1:0] LAST_SLOT = CW'(PACK_FACTOR - 1);

   logic [CW-1:0] pack_cnt;
   logic [LW-1:0] line_buf;
   logic [LW-1:0] line_wr;
   logic          accept;
   logic          line_done;
   logic          flush_req;
   logic          push_req;
   logic          pop;
   logic          push;
   logic          drop;

   assign accept    = i_valid && i_en;
   assign line_done = accept && (pack_cnt == LAST_SLOT);

`ifdef O_BUS_PACK_FLUSH_EN
   // A flush with an accepted word pushes that word too; an empty flush is a no-op.
   assign flush_req = i_flush && ((pack_cnt != '0) || accept);
`else
   assign flush_req = 1'b0;
`endif

   assign push_req = line_done || flush_req;
   assign pop      = o_valid && i_ready;
   assign push     = push_req && (!o_full || pop);
   assign drop     = push_req && o_full && !pop;

   // Line as it would look with the current word merged in. Slots above the
   // counter are always zero in line_buf, so a flushed partial line is zero-padded.
   always_comb begin
      line_wr = line_buf;
      for (int k = 0; k < PACK_FACTOR; k++) begin
         if (accept && (pack_cnt == CW'(k))) line_wr[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack_cnt   <= '0;
         line_buf   <= '0;
         o_overflow <= 1'b0;
      end else begin
         // Whether pushed or dropped, a finished line restarts packing at slot 0.
         if (push_req) begin
            pack_cnt <= '0;
            line_buf <= '0;
         end else if (accept) begin
            pack_cnt <= pack_cnt + 1'b1;
            line_buf <= line_wr;
         end
         if (drop) o_overflow <= 1'b1;
      end
   end

   o_bus_pack_line_fifo #(
      .W     (LW),
      .DEPTH (FIFO_DEPTH)
   ) u_line_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (push),
      .wr_dat (line_wr),
      .rd_vld (o_valid),
      .rd_rdy (i_ready),
      .rd_dat (o_data),
      .count  (o_count),
      .full   (o_full)
   );
endmodule

// File: tb/tb_o_bus_pack_fifo.sv
// Directed bench for o_bus_pack_fifo (DATA_WIDTH=16, PACK_FACTOR=4, FIFO_DEPTH=8).
module tb_o_bus_pack_fifo;
   logic        clk;
   logic        rst;
   logic        i_valid;
   logic [15:0] i_data;
   logic        i_en;
   logic        o_valid;
   logic [63:0] o_data;
   logic        i_ready;
   logic [3:0]  o_count;
   logic        o_full;
   logic        o_overflow;
`ifdef O_BUS_PACK_FLUSH_EN
   logic        i_flush;
`endif

   int n_cmp = 0;
   int n_err = 0;

   o_bus_pack_fifo #(
      .DATA_WIDTH  (16),
      .PACK_FACTOR (4),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef O_BUS_PACK_FLUSH_EN
      .i_flush    (i_flush),
`endif
      .i_valid    (i_valid),
      .i_data     (i_data),
      .i_en       (i_en),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .i_ready    (i_ready),
      .o_count    (o_count),
      .o_full     (o_full),
      .o_overflow (o_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic [15:0] d);
      i_valid = 1'b1;
      i_data  = d;
      tick();
      i_valid = 1'b0;
   endtask

   // Line n carries words n*256+1 .. n*256+4, word 0 at the LSBs.
   function automatic logic [63:0] mk_line(input int n);
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(n*256 + k + 1);
      return r;
   endfunction

   task automatic feed_line(input int n);
      for (int k = 0; k < 4; k++) word(16'(n*256 + k + 1));
   endtask

   // i_en / i_valid interleave table for the gap test.
   logic        tv [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   logic        te [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [15:0] td [8] = '{16'h000A, 16'h0055, 16'h0066, 16'h000B,
                           16'h0077, 16'h000C, 16'h0088, 16'h000D};

   initial begin
      rst     = 1'b1;
      i_valid = 1'b0;
      i_data  = '0;
      i_en    = 1'b1;
      i_ready = 1'b0;
`ifdef O_BUS_PACK_FLUSH_EN
      i_flush = 1'b0;
`endif
      #2;
      chk("rst_valid", 64'(o_valid), 64'h0);
      chk("rst_data", o_data, 64'h0);
      chk("rst_count", 64'(o_count), 64'h0);
      chk("rst_full", 64'(o_full), 64'h0);
      chk("rst_ovf", 64'(o_overflow), 64'h0);
      #10 rst = 1'b0;

      // Basic packing, streaming downstream.
      i_ready = 1'b1;
      word(16'h0001);
      word(16'h0002);
      word(16'h0003);
      chk("b_not_yet", 64'(o_valid), 64'h0);
      word(16'h0004);
      chk("b_valid", 64'(o_valid), 64'h1);
      chk("b_data", o_data, 64'h0004_0003_0002_0001);
      chk("b_count1", 64'(o_count), 64'h1);
      tick();
      chk("b_count0", 64'(o_count), 64'h0);
      chk("b_empty_valid", 64'(o_valid), 64'h0);
      chk("b_empty_data", o_data, 64'h0);
      i_ready = 1'b0;

      // Fill to full, overflow on the ninth line, drain in order.
      for (int n = 1; n <= 8; n++) feed_line(n);
      chk("f_full", 64'(o_full), 64'h1);
      chk("f_count8", 64'(o_count), 64'h8);
      chk("f_no_ovf", 64'(o_overflow), 64'h0);
      feed_line(9);
      chk("f_ovf", 64'(o_overflow), 64'h1);
      chk("f_count_hold", 64'(o_count), 64'h8);
      i_ready = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         chk($sformatf("f_drain%0d", n), o_data, mk_line(n));
         tick();
      end
      i_ready = 1'b0;
      chk("f_drained", 64'(o_valid), 64'h0);
      chk("f_ovf_sticky", 64'(o_overflow), 64'h1);

      // Asynchronous reset mid-line with 3 lines stored.
      for (int n = 1; n <= 3; n++) feed_line(n);
      word(16'h0055);
      word(16'h0066);
      chk("r_count3", 64'(o_count), 64'h3);
      #2 rst = 1'b1;
      #1;
      chk("r_valid", 64'(o_valid), 64'h0);
      chk("r_data", o_data, 64'h0);
      chk("r_count", 64'(o_count), 64'h0);
      chk("r_full", 64'(o_full), 64'h0);
      chk("r_ovf", 64'(o_overflow), 64'h0);
      #2 rst = 1'b0;
      word(16'h0021);
      word(16'h0022);
      word(16'h0023);
      word(16'h0024);
      chk("r_fresh_count", 64'(o_count), 64'h1);
      chk("r_fresh_data", o_data, 64'h0024_0023_0022_0021);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      chk("r_popped", 64'(o_count), 64'h0);

      // Line completes on the same edge as a pop while full.
      for (int n = 1; n <= 8; n++) feed_line(n);
      word(16'h0901);
      word(16'h0902);
      word(16'h0903);
      i_ready = 1'b1;
      word(16'h0904);
      chk("s_count8", 64'(o_count), 64'h8);
      chk("s_no_ovf", 64'(o_overflow), 64'h0);
      chk("s_head", o_data, mk_line(2));
      for (int n = 2; n <= 9; n++) begin
         chk($sformatf("s_drain%0d", n), o_data, mk_line(n));
         tick();
      end
      i_ready = 1'b0;
      chk("s_empty", 64'(o_count), 64'h0);
      chk("s_ovf_clear", 64'(o_overflow), 64'h0);

      // i_en low and i_valid gaps between words.
      for (int c = 0; c < 8; c++) begin
         i_valid = tv[c];
         i_en    = te[c];
         i_data  = td[c];
         tick();
      end
      i_valid = 1'b0;
      i_en    = 1'b1;
      chk("g_count", 64'(o_count), 64'h1);
      chk("g_data", o_data, 64'h000D_000C_000B_000A);
      // Pop still works with i_en low; the offered word is ignored.
      i_ready = 1'b1;
      i_en    = 1'b0;
      i_valid = 1'b1;
      i_data  = 16'h0099;
      tick();
      i_ready = 1'b0;
      i_valid = 1'b0;
      i_en    = 1'b1;
      chk("g_pop_en_low", 64'(o_count), 64'h0);
      feed_line(0);
      chk("g_next_line", o_data, mk_line(0));
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;

`ifdef O_BUS_PACK_FLUSH_EN
      word(16'h0011);
      word(16'h0022);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("x_count", 64'(o_count), 64'h1);
      chk("x_data", o_data, 64'h0000_0000_0022_0011);
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("x_empty_flush", 64'(o_count), 64'h1);
      i_flush = 1'b1;
      word(16'h0033);
      i_flush = 1'b0;
      chk("x_word_flush", 64'(o_count), 64'h2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
